// File: rtl/mmio_io_ctrl_if.sv
// rtl/mmio_io_ctrl_if.sv - MEM-stage IO bus between the core and the MMIO peripheral block
interface mmio_io_ctrl_if;
  logic        io_ce_i;
  logic        io_we_i;
  logic [31:0] io_addr_i;
  logic [31:0] io_data_i;
  logic [31:0] io_data_o;

  modport master (
    output io_ce_i, io_we_i, io_addr_i, io_data_i,
    input  io_data_o
  );

  modport slave (
    input  io_ce_i, io_we_i, io_addr_i, io_data_i,
    output io_data_o
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - MMIO block: LED, switch sync, timer, optional UART TX with FIFO (IO_UART_EN)
module mmio_io_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_W      = 16,
  parameter int SW_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_io_ctrl_if.slave     io,
  input  logic [SW_W-1:0]   sw_i,
  output logic [LED_W-1:0]  led_o,
  output logic              uart_tx_o
);

  localparam logic [2:0] A_LED   = 3'd1;
  localparam logic [2:0] A_SW    = 3'd2;
  localparam logic [2:0] A_TIMER = 3'd3;

  logic [2:0]      sel;
  logic            wr;
  logic            rd;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [31:0]      timer_q;
  logic [31:0]      rdata;

  assign sel = io.io_addr_i[4:2];
  assign wr  = io.io_ce_i & io.io_we_i;
  assign rd  = io.io_ce_i & ~io.io_we_i;

  logic unused_addr;
  assign unused_addr = ^{io.io_addr_i[31:5], io.io_addr_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      timer_q <= '0;
    end else begin
      if (wr && sel == A_LED) led_q <= io.io_data_i[LED_W-1:0];
      sw_meta <= sw_i;
      sw_sync <= sw_meta;
      // A write on the same edge wins over the free-running increment
      if (wr && sel == A_TIMER) timer_q <= io.io_data_i;
      else                      timer_q <= timer_q + 32'd1;
    end
  end

  assign led_o = led_q;

`ifdef IO_UART_EN
  localparam logic [2:0] A_TXD  = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int DW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, drop, pop, busy;
  logic          overflow_q;
  state_t        state_q, state_n;
  logic [7:0]    sh_q, sh_n;
  logic [2:0]    bit_q, bit_n;
  logic [DW-1:0] div_q, div_n;
  logic          tx_q, tx_n;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Push is judged against the pre-edge full flag even if a pop happens on the same edge
  assign push  = wr && (sel == A_TXD) && !full;
  assign drop  = wr && (sel == A_TXD) && full;
  assign busy  = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= io.io_data_i[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      sh_q       <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow_q <= 1'b1;
      else if (wr && sel == A_STAT && io.io_data_i[3]) overflow_q <= 1'b0;
      state_q <= state_n;
      sh_q    <= sh_n;
      bit_q   <= bit_n;
      div_q   <= div_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n = state_q;
    sh_n    = sh_q;
    bit_n   = bit_q;
    div_n   = div_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = fifo_mem[rd_ptr[AW-1:0]];
          div_n   = '0;
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (div_q == DIV_LAST) begin
          div_n   = '0;
          bit_n   = '0;
          tx_n    = sh_q[0];
          state_n = S_DATA;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (div_q == DIV_LAST) begin
          div_n = '0;
          if (bit_q == 3'd7) begin
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            bit_n = bit_q + 3'd1;
            sh_n  = {1'b0, sh_q[7:1]};
            tx_n  = sh_q[1];
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      S_STOP: begin
        if (div_q == DIV_LAST) begin
          div_n   = '0;
          state_n = S_IDLE;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign uart_tx_o = tx_q;
`else
  localparam int unused_cfg = CLK_HZ + BAUD + FIFO_DEPTH;
  assign uart_tx_o = 1'b1;
`endif

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (sel)
        A_LED:   rdata = 32'(led_q);
        A_SW:    rdata = 32'(sw_sync);
        A_TIMER: rdata = timer_q;
`ifdef IO_UART_EN
        A_STAT:  rdata = {28'b0, overflow_q, busy, full, empty};
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign io.io_data_o = rdata;

endmodule
